// File: rtl/pes_lcd_panel_if.sv
// HD44780-style parallel bus between the pes_lcd controller (master) and the panel model (slave).
interface pes_lcd_panel_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_db_in;
    logic [7:0] lcd_db_out;
    logic       lcd_db_oe;

    modport master (
        output lcd_e, lcd_rs, lcd_rw, lcd_db_in,
        input  lcd_db_out, lcd_db_oe
    );

    modport slave (
        input  lcd_e, lcd_rs, lcd_rw, lcd_db_in,
        output lcd_db_out, lcd_db_oe
    );
endinterface

// File: rtl/pes_lcd_panel.sv
// Cycle-accurate HD44780-style panel responder: E synchroniser, instruction subset, DDRAM, bus reads.
// Busy timing is modelled only when PES_LCD_PANEL_BUSY_EN is defined; otherwise only the clear sweep is busy.
//
// state    | meaning
// IDLE     | ready, writes are accepted (BUSY=0)
// EXEC     | busy countdown after an accepted write
// CLEAR    | sweeping 0x20 into every DDRAM cell, one per cycle
// (oe_q=1) | READ: panel drives the bus until E falls; runs alongside the states above
module pes_lcd_panel #(
    parameter int unsigned DEPTH        = 80,
    parameter int unsigned BUSY_CYCLES  = 37,
    parameter int unsigned CLEAR_CYCLES = 152
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pes_lcd_panel_if.slave     bus,
    output logic               busy_o,
    output logic [6:0]         addr_o,
    output logic               disp_on_o,
    output logic               ovr_o,
    input  logic [6:0]         mon_addr_i,
    output logic [7:0]         mon_data_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic [6:0] LAST = 7'(DEPTH - 1);

`ifdef PES_LCD_PANEL_BUSY_EN
    localparam logic [15:0] BUSY_LD  = 16'(BUSY_CYCLES);
    localparam logic [15:0] CLEAR_LD = 16'(CLEAR_CYCLES);
`else
    // Timing disabled: both loads collapse to zero so writes finish without BUSY.
    localparam logic [15:0] BUSY_LD  = 16'(BUSY_CYCLES * 0);
    localparam logic [15:0] CLEAR_LD = 16'(CLEAR_CYCLES * 0);
`endif

    logic        e1_q, e2_q, e3_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_dec;
    logic [6:0]  sweep_q, sweep_d;
    logic [6:0]  addr_q, addr_d;
    logic        id_q, id_d;
    logic        disp_q, disp_d;
    logic        ovr_q, ovr_d;
    logic        oe_q, oe_d;
    logic [7:0]  dout_q, dout_d;

    logic [7:0]  mem_q [DEPTH];
    logic        mem_we;
    logic [6:0]  mem_wa;
    logic [7:0]  mem_wd;

    logic        rise, fall, busy;
    logic [15:0] ld_val;
    logic        clr;

    function automatic logic [6:0] step(input logic [6:0] a, input logic inc);
        if (inc) return (a == LAST) ? 7'd0 : a + 7'd1;
        else     return (a == 7'd0) ? LAST : a - 7'd1;
    endfunction

    assign rise = e2_q & ~e3_q;
    assign fall = ~e2_q & e3_q;
    assign busy = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sweep_d = sweep_q;
        addr_d  = addr_q;
        id_d    = id_q;
        disp_d  = disp_q;
        ovr_d   = ovr_q;
        oe_d    = oe_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;
        mem_wa  = addr_q;
        mem_wd  = bus.lcd_db_in;
        ld_val  = BUSY_LD;
        clr     = 1'b0;
        cnt_dec = (cnt_q == 16'd0) ? 16'd0 : cnt_q - 16'd1;

        case (state_q)
            ST_EXEC: begin
                cnt_d = cnt_dec;
                if (cnt_q <= 16'd1) state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                cnt_d   = cnt_dec;
                mem_we  = 1'b1;
                mem_wa  = sweep_q;
                mem_wd  = 8'h20;
                sweep_d = sweep_q + 7'd1;
                if (sweep_q == LAST) state_d = (cnt_q > 16'd1) ? ST_EXEC : ST_IDLE;
            end
            default: ;
        endcase

        if (rise && bus.lcd_rw) begin
            oe_d = 1'b1;
            if (bus.lcd_rs) begin
                dout_d = mem_q[addr_q];
                if (!busy) addr_d = step(addr_q, id_q);
            end else begin
                dout_d = {busy, addr_q};
            end
        end else if (fall && oe_q) begin
            oe_d   = 1'b0;
            dout_d = 8'h00;
        end else if (fall && !bus.lcd_rw) begin
            if (busy) begin
                ovr_d = 1'b1;
            end else begin
                if (bus.lcd_rs) begin
                    mem_we = 1'b1;
                    addr_d = step(addr_q, id_q);
                end else begin
                    // Decode by highest set bit; unlisted ranges only cost busy time.
                    casez (bus.lcd_db_in)
                        8'b1???????: if (bus.lcd_db_in[6:0] <= LAST) addr_d = bus.lcd_db_in[6:0];
                        8'b00001???: disp_d = bus.lcd_db_in[2];
                        8'b000001??: id_d = bus.lcd_db_in[1];
                        8'b0000001?: begin
                            addr_d = 7'd0;
                            ld_val = CLEAR_LD;
                        end
                        8'b00000001: begin
                            addr_d = 7'd0;
                            id_d   = 1'b1;
                            clr    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = CLEAR_LD;
                    sweep_d = 7'd0;
                end else if (ld_val != 16'd0) begin
                    state_d = ST_EXEC;
                    cnt_d   = ld_val;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e1_q    <= 1'b0;
            e2_q    <= 1'b0;
            e3_q    <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            sweep_q <= 7'd0;
            addr_q  <= 7'd0;
            id_q    <= 1'b1;
            disp_q  <= 1'b0;
            ovr_q   <= 1'b0;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            e1_q    <= bus.lcd_e;
            e2_q    <= e1_q;
            e3_q    <= e2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sweep_q <= sweep_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            disp_q  <= disp_d;
            ovr_q   <= ovr_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
        end
    end

    // DDRAM keeps its contents through reset; only an in-flight write is suppressed.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) mem_q[mem_wa] <= mem_wd;
    end

    assign mon_data_o     = (32'(mon_addr_i) < DEPTH) ? mem_q[mon_addr_i] : 8'h00;
    assign busy_o         = busy;
    assign addr_o         = addr_q;
    assign disp_on_o      = disp_q;
    assign ovr_o          = ovr_q;
    assign bus.lcd_db_out = dout_q;
    assign bus.lcd_db_oe  = oe_q;

endmodule

// File: tb/tb_pes_lcd_panel.sv
// Directed bench for pes_lcd_panel: read data checked through a scoreboard queue, panel state checked inline.
module tb_pes_lcd_panel;

`ifdef PES_LCD_PANEL_BUSY_EN
    localparam int       EXP_BUSY  = 37;
    localparam int       EXP_CLEAR = 152;
    localparam int       EXP_HOME  = 152;
    localparam bit       HAS_BUSY  = 1'b1;
`else
    localparam int       EXP_BUSY  = 0;
    localparam int       EXP_CLEAR = 80;
    localparam int       EXP_HOME  = 0;
    localparam bit       HAS_BUSY  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy, disp_on, ovr;
    logic [6:0] addr;
    logic [6:0] mon_addr = 7'd0;
    logic [7:0] mon_data;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_exp;
    logic       oe_prev = 1'b0;

    always #5 clk = ~clk;

    pes_lcd_panel_if bus();

    pes_lcd_panel dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .busy_o     (busy),
        .addr_o     (addr),
        .disp_on_o  (disp_on),
        .ovr_o      (ovr),
        .mon_addr_i (mon_addr),
        .mon_data_o (mon_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, want);
        end
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] db);
        @(negedge clk);
        bus.lcd_rs    = rs;
        bus.lcd_rw    = 1'b0;
        bus.lcd_db_in = db;
        bus.lcd_e     = 1'b1;
        repeat (3) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic rs, input logic [7:0] want);
        exp_q.push_back(want);
        @(negedge clk);
        bus.lcd_rs = rs;
        bus.lcd_rw = 1'b1;
        bus.lcd_e  = 1'b1;
        repeat (5) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (4) @(negedge clk);
        bus.lcd_rw = 1'b0;
        chk("oe_after_read", bus.lcd_db_oe, 1'b0);
        chk("dbout_after_read", bus.lcd_db_out, 8'h00);
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        measure_busy(n);
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy still high after %0d cycles", n);
        end
    endtask

    task automatic cmd(input logic rs, input logic [7:0] db);
        wait_idle();
        bus_write(rs, db);
    endtask

    task automatic peek(input logic [6:0] a, output logic [7:0] d);
        mon_addr = a;
        #1;
        d = mon_data;
    endtask

    // Scoreboard monitor: each rising OE presents one read value.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.lcd_db_oe === 1'b1 && oe_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_read: got=0x%0h want=none", bus.lcd_db_out);
                end else begin
                    sb_exp = exp_q.pop_front();
                    chk("sb_read", bus.lcd_db_out, sb_exp);
                end
            end
            oe_prev = bus.lcd_db_oe;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int         n, nclr, errs;
        logic [7:0] d;

        bus.lcd_e     = 1'b0;
        bus.lcd_rs    = 1'b0;
        bus.lcd_rw    = 1'b0;
        bus.lcd_db_in = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", addr, 7'd0);
        chk("rst_disp", disp_on, 1'b0);
        chk("rst_ovr", ovr, 1'b0);
        chk("rst_oe", bus.lcd_db_oe, 1'b0);
        chk("rst_dbout", bus.lcd_db_out, 8'h00);

        bus_read(1'b0, 8'h00);

        cmd(1'b0, 8'h85);
        measure_busy(n);
        chk("busy_len_setaddr", n, EXP_BUSY);
        chk("addr_set5", addr, 7'd5);
        cmd(1'b1, 8'hAA);
        measure_busy(n);
        chk("busy_len_data", n, EXP_BUSY);
        peek(7'd5, d);
        chk("ddram5", d, 8'hAA);
        chk("addr_inc6", addr, 7'd6);

        cmd(1'b0, 8'h85);
        wait_idle();
        bus_read(1'b1, 8'hAA);
        chk("addr_after_dread", addr, 7'd6);

        cmd(1'b0, 8'h80);
        cmd(1'b0, 8'h04);
        cmd(1'b1, 8'h41);
        peek(7'd0, d);
        chk("ddram0", d, 8'h41);
        chk("addr_wrap_dec", addr, 7'd79);
        cmd(1'b1, 8'h42);
        peek(7'd79, d);
        chk("ddram79", d, 8'h42);
        chk("addr_dec78", addr, 7'd78);

        cmd(1'b0, 8'hD0);
        chk("addr_oob_ignored", addr, 7'd78);
        cmd(1'b0, 8'hCF);
        chk("addr_set79", addr, 7'd79);

        cmd(1'b0, 8'h0C);
        chk("disp_on", disp_on, 1'b1);
        measure_busy(n);
        chk("busy_len_disp", n, EXP_BUSY);

        cmd(1'b0, 8'h02);
        measure_busy(n);
        chk("busy_len_home", n, EXP_HOME);
        chk("addr_home", addr, 7'd0);
        chk("ovr_before_clear", ovr, 1'b0);

        wait_idle();
        bus_write(1'b0, 8'h01);
        fork
            measure_busy(nclr);
            begin
                repeat (5) @(posedge clk);
                bus_write(1'b1, 8'h55);
                bus_read(1'b0, 8'h80);
            end
        join
        chk("busy_len_clear", nclr, EXP_CLEAR);
        chk("ovr_sticky", ovr, 1'b1);
        chk("addr_after_clear", addr, 7'd0);
        errs = 0;
        for (int i = 0; i < 80; i++) begin
            peek(7'(i), d);
            if (d !== 8'h20) errs++;
        end
        chk("sweep_cells", errs, 0);
        peek(7'd100, d);
        chk("mon_oob", d, 8'h00);

        cmd(1'b0, 8'h90);
        cmd(1'b1, 8'h77);
        chk("addr_inc_after_clear", addr, 7'd17);
        peek(7'd16, d);
        chk("ddram16", d, 8'h77);

        cmd(1'b0, 8'h90);
        bus_read(1'b0, {HAS_BUSY, 7'h10});

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst2_busy", busy, 1'b0);
        chk("rst2_ovr", ovr, 1'b0);
        chk("rst2_addr", addr, 7'd0);
        peek(7'd16, d);
        chk("rst2_ddram_kept", d, 8'h77);

        repeat (4) @(posedge clk);
        chk("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pes_lcd_panel.md
# pes_lcd_panel

Cycle-accurate behavioural responder for the HD44780-style parallel bus driven by `pes_lcd`: the panel side of the interface. It samples `LCD_E`/`LCD_RS`/`LCD_RW`/`LCD_DB`, executes the instruction subset the controller issues, holds a display-data RAM (DDRAM) and drives the data bus back on reads. It sits opposite `pes_lcd` in integration benches and gives verification a checkable panel state.

## Interface
- `DEPTH`, 80: number of DDRAM cells; the address range is 0..DEPTH-1.
- `BUSY_CYCLES`, 37: BUSY duration after a non-clear write, in CLK cycles.
- `CLEAR_CYCLES`, 152: BUSY duration after Clear (0x01) or Home (0x02). Must be ≥ DEPTH.
- `CLK  in  1`: single clock. All logic is on the rising edge.
- `RST  in  1`: synchronous, active-high reset.
- `LCD_E  in  1`: enable strobe. Asynchronous to CLK and synchronised internally.
- `LCD_RS  in  1`: 0 = instruction/status, 1 = data.
- `LCD_RW  in  1`: 0 = write, 1 = read.
- `LCD_DB_IN  in  8`: bus value driven by the controller.
- `LCD_DB_OUT  out  8`: bus value driven by the panel on reads.
- `LCD_DB_OE  out  1`: panel drives the bus. The integration tristate is built from this.
- `BUSY  out  1`: busy flag (DB7 of the status read).
- `ADDR  out  7`: DDRAM address counter.
- `DISP_ON  out  1`: D bit of the last Display Control instruction.
- `OVR  out  1`: sticky flag; a write arrived while BUSY.
- `MON_ADDR  in  7`: monitor read address.
- `MON_DATA  out  8`: DDRAM[MON_ADDR], combinational. Out-of-range addresses return 0x00.

## Operation
- **E synchroniser:** `e1`→`e2`→`e3`; rise = e2&~e3, fall = ~e2&e3. RS, RW and DB_IN are sampled in the rise/fall-detect cycle. The driver must hold them stable from E rise until 3 CLK after E fall.
- **States:**
  - IDLE: rise with RW=1 → READ; fall with RW=0 → execute the write.
  - READ: on entry, OE=1 and DB_OUT is loaded. Status read (RS=0) gives {BUSY, ADDR}. Data read (RS=1) gives DDRAM[ADDR]. On fall, OE=0 and the state returns to IDLE or EXEC (whichever was active). A data read steps ADDR by ±1 per I/D.
  - EXEC: busy countdown; BUSY=1; at 0, go to IDLE.
  - CLEAR: sweep writes 0x20 to cells 0..DEPTH-1, one per cycle, then go to EXEC for the remaining CLEAR_CYCLES-DEPTH.
- **Writes:** a write accepted while BUSY=0 decodes as follows.
  - RS=1: DDRAM[ADDR] ← DB_IN, then ADDR steps per I/D.
  - RS=0, instruction by highest set bit:
    - 0x80|a: ADDR ← a if a < DEPTH, else ignored.
    - 0x20–0x3F (function set): no state change.
    - 0x08–0x0F: DISP_ON ← DB[2].
    - 0x04–0x07: I/D ← DB[1]; S is ignored.
    - 0x02–0x03: ADDR ← 0.
    - 0x01: ADDR ← 0, I/D ← 1, go to CLEAR.
    - 0x00: no operation.
- **Write while BUSY=1:** dropped and OVR ← 1.
- **Reads:** served regardless of BUSY and never set OVR. A data read during EXEC/CLEAR returns the current cell, but its ADDR step is suppressed.
- **Address wrap:** increment DEPTH-1 → 0; decrement 0 → DEPTH-1.
- **Busy counter:** loaded with BUSY_CYCLES, or CLEAR_CYCLES for 0x01/0x02. It counts down 1 per cycle, and BUSY drops in the cycle the counter reaches 0.
- **Reset (synchronous):** BUSY=0, ADDR=0, I/D=1, DISP_ON=0, OVR=0, OE=0, DB_OUT=0x00, e1..e3=0, state IDLE.
  - DDRAM contents are not reset.
  - Reset mid-sweep or mid-count aborts it.
  - E held high across reset release is seen as a new rising edge.

## Timing
- A write takes effect at the 3rd rising CLK edge after E falls. The first edge that samples E low counts as edge 1.
- BUSY rises on that same edge. A following write is accepted only if its fall is detected with BUSY=0.
- Read: OE and DB_OUT are valid from the 3rd rising edge after E rises, held until the 3rd edge after E falls, then OE=0 and DB_OUT=0x00.
- Clear: BUSY high for exactly CLEAR_CYCLES cycles. Cell k is written k+1 cycles after commit.

## Configuration
- `PES_LCD_PANEL_BUSY_EN` defined: busy timing is modelled as above.
- Not defined:
  - BUSY_CYCLES and CLEAR_CYCLES are treated as 0.
  - BUSY is asserted only during the Clear sweep (exactly DEPTH cycles).
  - All other writes complete with BUSY=0, and OVR can set only during a sweep.

## Test plan
- Reset; read status (RS=0, RW=1) → DB_OUT=0x00, OE=1 only while E is high.
- Write 0x80|0x05, wait BUSY=0, then write data 0xAA → MON_DATA[5]=0xAA, ADDR=6. BUSY held for 37 cycles after each write.
- Write 0x04 (decrement) with ADDR=0, then write data 0x41 → DDRAM[0]=0x41, ADDR=79 (wrap).
- Write 0x01, then sample → BUSY high for 152 cycles, all 80 cells =0x20, ADDR=0. A data write issued mid-sweep is dropped and OVR=1.
- Mid-EXEC status read → DB_OUT[7]=1 and DB_OUT[6:0]=ADDR. Assert RST for 1 cycle → BUSY=0, OVR=0, DDRAM unchanged.
- Build without the macro: write 0x0C → DISP_ON=1, BUSY never set. Then 0x01 → BUSY high for exactly 80 cycles.
